// File: rtl/mvm_result_drain.sv
// mvm_result_drain: captures one K-word MVM result frame, requantises each
// word (arithmetic shift + saturation) and streams it out over a
// valid/ready interface through a K-entry FIFO.
module mvm_result_drain #(
  parameter int K     = 32,
  parameter int B     = 8,
  parameter int LOG_K = 5,
  parameter int SHIFT = 0,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_in,
  input  logic signed [2*B-1:0]   data_in,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int CW = LOG_K + 1;  // fill level must represent 0..K
  localparam int EW = OUT_W + 1;  // FIFO entry: {last flag, data}

  localparam logic [LOG_K-1:0] PTR_LAST = LOG_K'(K - 1);
  localparam logic [LOG_K-1:0] PTR_ZERO = {LOG_K{1'b0}};
  localparam logic [LOG_K-1:0] PTR_ONE  = LOG_K'(1);
  localparam logic [CW-1:0]    FILL_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    FILL_ONE  = CW'(1);

  // Saturation bounds expressed at the input word width.
  localparam logic signed [2*B-1:0] SAT_HI = {{(2*B-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [2*B-1:0] SAT_LO = {{(2*B-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Arithmetic right shift (floor) followed by clamp to the OUT_W range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [2*B-1:0] x);
    logic signed [2*B-1:0] q;
    logic [OUT_W-1:0]      r;
    q = x >>> SHIFT;
    if (q > SAT_HI) begin
      r = SAT_HI[OUT_W-1:0];
    end else if (q < SAT_LO) begin
      r = SAT_LO[OUT_W-1:0];
    end else begin
      r = q[OUT_W-1:0];
    end
    return r;
  endfunction

  // Pointer increment with explicit wrap at K-1 (K need not be a power of two).
  function automatic logic [LOG_K-1:0] ptr_inc(input logic [LOG_K-1:0] p);
    logic [LOG_K-1:0] r;
    if (p == PTR_LAST) begin
      r = PTR_ZERO;
    end else begin
      r = p + PTR_ONE;
    end
    return r;
  endfunction

  state_t                 state_r;
  state_t                 state_next_s;
  logic [LOG_K-1:0]       cap_cnt_r;
  logic [LOG_K-1:0]       wr_ptr_r;
  logic [LOG_K-1:0]       rd_ptr_r;
  logic [CW-1:0]          fill_r;
  logic [EW-1:0]          mem_r [0:K-1];
  logic                   out_valid_r;
  logic                   out_last_r;
  logic [OUT_W-1:0]       out_data_r;
  logic                   busy_r;
  logic                   overrun_r;

  logic                   wr_en_s;
  logic                   rd_en_s;
  logic [EW-1:0]          wr_entry_s;
  logic [CW-1:0]          fill_after_rd_s;
  logic [CW-1:0]          fill_next_s;
  logic [LOG_K-1:0]       rd_ptr_next_s;
  logic [EW-1:0]          head_next_s;

  // Next-state logic: a frame is K contiguous capture cycles, then a drain
  // that ends when the consumer takes the word tagged as last.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (done_in) begin
          state_next_s = CAPTURE;
        end else begin
          state_next_s = IDLE;
        end
      end
      CAPTURE: begin
        if (cap_cnt_r == PTR_LAST) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = CAPTURE;
        end
      end
      DRAIN: begin
        if (rd_en_s && out_last_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture counter: cleared on frame start, counts one word per capture cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_cnt_r <= PTR_ZERO;
    end else if (state_r == IDLE && done_in) begin
      cap_cnt_r <= PTR_ZERO;
    end else if (state_r == CAPTURE) begin
      cap_cnt_r <= cap_cnt_r + PTR_ONE;
    end else begin
      cap_cnt_r <= cap_cnt_r;
    end
  end

  // FIFO control and next head: when the FIFO would be empty after this
  // cycle's pop, the word written this cycle becomes the head directly.
  always_comb begin
    wr_en_s    = (state_r == CAPTURE);
    rd_en_s    = out_valid_r && out_ready;
    wr_entry_s = {(cap_cnt_r == PTR_LAST), requant(data_in)};

    if (rd_en_s) begin
      fill_after_rd_s = fill_r - FILL_ONE;
      rd_ptr_next_s   = ptr_inc(rd_ptr_r);
    end else begin
      fill_after_rd_s = fill_r;
      rd_ptr_next_s   = rd_ptr_r;
    end

    if (wr_en_s) begin
      fill_next_s = fill_after_rd_s + FILL_ONE;
    end else begin
      fill_next_s = fill_after_rd_s;
    end

    if (fill_after_rd_s == FILL_ZERO) begin
      head_next_s = wr_entry_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage; contents are don't-care until written so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_next_s;
      fill_r   <= fill_next_s;
    end
  end

  // Registered output stage mirroring the FIFO head; holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
    end else if (fill_next_s != FILL_ZERO) begin
      out_valid_r <= 1'b1;
      out_last_r  <= head_next_s[OUT_W];
      out_data_r  <= head_next_s[OUT_W-1:0];
    end else begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= out_data_r;
    end
  end

  // Busy tracks the frame state; a start request while busy latches overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r    <= (state_next_s != IDLE);
      overrun_r <= overrun_r | (done_in & busy_r);
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_mvm_result_drain.sv
// Testbench for mvm_result_drain (K=4, SHIFT=2, OUT_W=8): table of input
// words with expected requantised outputs, scoreboard of expected words,
// and hand sequences for stall, overrun, reset and back-to-back frames.
module tb_mvm_result_drain;

  localparam int K     = 4;
  localparam int B     = 8;
  localparam int LOG_K = 2;
  localparam int SHIFT = 2;
  localparam int OUT_W = 8;

  logic                    clk;
  logic                    reset;
  logic                    done_in;
  logic signed [2*B-1:0]   data_in;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;
  logic                    overrun;

  mvm_result_drain #(
    .K(K), .B(B), .LOG_K(LOG_K), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic signed [2*B-1:0] din;
    int                    exp;
  } vec_t;

  typedef struct {
    int data;
    bit last;
  } sb_t;

  vec_t tbl [16];
  sb_t  exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_overrun = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word is compared with the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got %0d expected no word at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_last", out_last, e.last);
        end
      end
    end
  end

  // Run one frame from table slot f. c counts cycles from the done pulse (c=0).
  task automatic run_frame(input int f, input int rdy_from, input bit toggle, input int ovr_at);
    int c;
    bit fin;
    bit last_seen;
    c = 0;
    fin = 1'b0;
    last_seen = 1'b0;
    while (!fin) begin
      done_in = (c == 0) || (ovr_at > 0 && c == ovr_at);
      if (c >= 1 && c <= K) begin
        data_in = tbl[f*K + c - 1].din;
        exp_q.push_back('{tbl[f*K + c - 1].exp, (c == K)});
      end else begin
        data_in = '0;
      end
      if (toggle && c >= 1 && c <= K) begin
        out_ready = (c % 2 == 1);
      end else begin
        out_ready = (c >= rdy_from);
      end
      @(negedge clk);
      if (c == 1) begin
        chk("busy_rise", busy, 1);
        chk("valid_early", out_valid, 0);
      end
      if (last_seen) begin
        chk("busy_fall", busy, 0);
        last_seen = 1'b0;
      end
      if (rdy_from > 2 && c >= 2 && c < rdy_from) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, tbl[f*K].exp);
      end
      if (rdy_from > 2 && c >= rdy_from && c < rdy_from + K) begin
        chk("drain_valid", out_valid, 1);
      end
      if (ovr_at > 0 && c == ovr_at + 1) begin
        chk("overrun_set", overrun, 1);
      end
      if (out_valid && out_ready && out_last) begin
        last_seen = 1'b1;
      end
      if (c >= K + 1 && !busy && !out_valid) begin
        fin = 1'b1;
      end else if (c >= 60) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_timeout: got busy=%0d valid=%0d expected idle by cycle 60", busy, out_valid);
        fin = 1'b1;
      end
      step();
      c++;
    end
    done_in   = 1'b0;
    out_ready = 1'b0;
    chk("sb_empty", exp_q.size(), 0);
    chk("overrun_state", overrun, exp_overrun);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{16'sd100,    25};
    tbl[1]  = '{-16'sd7,     -2};
    tbl[2]  = '{16'sd600,    127};
    tbl[3]  = '{-16'sd1000,  -128};
    tbl[4]  = '{16'sd3,      0};
    tbl[5]  = '{-16'sd1,     -1};
    tbl[6]  = '{-16'sd5,     -2};
    tbl[7]  = '{16'sd511,    127};
    tbl[8]  = '{16'sd508,    127};
    tbl[9]  = '{-16'sd512,   -128};
    tbl[10] = '{16'sd32767,  127};
    tbl[11] = '{-16'sd32768, -128};
    tbl[12] = '{16'sd4,      1};
    tbl[13] = '{-16'sd4,     -1};
    tbl[14] = '{16'sd0,      0};
    tbl[15] = '{-16'sd508,   -127};

    reset     = 1'b0;
    done_in   = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    reset = 1'b1;
    step();

    // Basic frame, consumer always ready.
    run_frame(0, 0, 1'b0, -1);
    // Consumer stalls until cycle D+10.
    run_frame(0, 10, 1'b0, -1);
    // Ready toggling during capture, remaining table frames.
    run_frame(1, 0, 1'b1, -1);
    // Second start at D+3 while busy.
    exp_overrun = 1'b1;
    run_frame(2, 0, 1'b0, 3);
    // Overrun stays set across a later clean frame.
    run_frame(3, 0, 1'b0, -1);

    // Reset asserted mid-frame at D+2.
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    data_in = tbl[0].din;
    step();
    data_in = tbl[1].din;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_data", out_data, 0);
    exp_q.delete();
    exp_overrun = 1'b0;
    data_in = '0;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("post_rst_idle_valid", out_valid, 0);
    chk("post_rst_idle_busy", busy, 0);
    run_frame(0, 0, 1'b0, -1);

    // Back-to-back frames: next start one cycle after busy falls.
    run_frame(1, 0, 1'b0, -1);
    run_frame(2, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
